spi_flash_arbiter: RTL and testbench
====================================

# spi_flash_arbiter

Two-master arbiter for the single SPI boot flash port. It shares the flash pins between the bootstrap engine, which copies boot code from flash into the AHB-Lite SRAM, and the external SPI host, which programs the flash. Arbitration uses a req/gnt handshake, enforces a chip-select deselect guard between owners, and provides a hold-timeout watchdog. It sits between both SPI masters and the flash device pins, in the HCLK domain.

## Interface
- GUARD_CYCLES, 4: HCLK cycles FLASH_SS is held high between owners; legal range 1..255.
- TIMEOUT_CYCLES, 0: maximum grant hold in HCLK cycles; 0 disables the watchdog; 24-bit counter.
- SCK_IDLE, 0: level driven on FLASH_SCK when no master is routed.

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- DEBUG_MODE  in  1  1 = boot requests are ignored in arbitration.
- BOOT_REQ  in  1  bootstrap engine requests the flash.
- BOOT_GNT  out  1  bootstrap engine owns the flash.
- BOOT_SCK, BOOT_SDO, BOOT_SS  in  1 each  bootstrap SPI outputs; SS is active-low.
- BOOT_SDI  out  1  flash data to the bootstrap engine.
- HOST_REQ, HOST_GNT, HOST_SCK, HOST_SDO, HOST_SS, HOST_SDI  same as the BOOT_* set, for the external host.
- FLASH_SCK, FLASH_SDO, FLASH_SS  out  1 each  flash device pins.
- FLASH_SDI  in  1  flash serial output.
- OWNER  out  2  00 none, 01 boot, 10 host, 11 guard.
- TIMEOUT_ERR  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GNT_BOOT, GNT_HOST, GUARD. The state and all counters are registered.
- Arbitration happens in IDLE and on the last GUARD cycle:
  - BOOT_REQ wins when DEBUG_MODE=0.
  - Otherwise HOST_REQ wins.
  - With no eligible request, go to IDLE.
- GNT_x: stay while REQ_x=1. When REQ_x=0, go to GUARD with the guard counter loaded.
- Watchdog: when TIMEOUT_CYCLES>0 and the grant has lasted TIMEOUT_CYCLES cycles, the block:
  - forces GUARD;
  - pulses TIMEOUT_ERR;
  - sets lockout_x.
- lockout_x makes master x ineligible. It clears when REQ_x is sampled 0.
- DEBUG_MODE never preempts a current owner. It affects the next arbitration only.
- Routing is combinational from the registered state:
  - The granted master's SCK, SDO and SS drive the FLASH_* pins.
  - Otherwise FLASH_SS=1, FLASH_SCK=SCK_IDLE and FLASH_SDO=0.
- BOOT_SDI and HOST_SDI are both FLASH_SDI, unconditionally.
- GNT outputs and OWNER are decoded from the state register, so they are glitch-free.
- Each master must keep its SS high until its GNT is seen. The arbiter does not check this; SS from a non-owner is simply not routed.

## Timing
- Reset values:
  - state IDLE, counters 0, lockouts 0;
  - BOOT_GNT=0, HOST_GNT=0, OWNER=00, TIMEOUT_ERR=0;
  - FLASH_SS=1, FLASH_SCK=SCK_IDLE, FLASH_SDO=0.
- Grant latency: a REQ sampled high at edge t in IDLE gives GNT=1 after edge t, i.e. one cycle.
- Release: REQ sampled low at edge t gives GNT=0 and OWNER=11 after edge t.
- GUARD lasts exactly GUARD_CYCLES cycles. At its end the next owner's GNT is asserted directly, with no IDLE cycle.
- Back-to-back: the minimum FLASH_SS-high gap between owners is GUARD_CYCLES cycles.
- Same-master re-request during GUARD still waits out the full guard.
- Simultaneous BOOT_REQ and HOST_REQ with DEBUG_MODE=0: boot is granted; the host waits.
- Watchdog: the grant cycle counter starts at 1 on the first GNT cycle. On the cycle the count equals TIMEOUT_CYCLES:
  - TIMEOUT_ERR=1 for that cycle;
  - GNT drops after that edge.
- HRESET asserted mid-grant: the next edge returns everything to reset values. FLASH_SS goes high at once, and any partial SPI transfer is abandoned.

## Test plan
- Reset, then HOST_REQ=1 only → HOST_GNT=1 one cycle later, OWNER=10, FLASH_SCK/SDO/SS follow the HOST_* inputs, FLASH_SDI reaches both SDI outputs.
- BOOT_REQ and HOST_REQ rise on the same edge, DEBUG_MODE=0, GUARD_CYCLES=4 → BOOT_GNT first. BOOT_REQ drops → exactly 4 cycles of OWNER=11 with FLASH_SS=1, then HOST_GNT=1.
- DEBUG_MODE=1 with both requesting → HOST_GNT only, and BOOT_GNT stays 0 throughout. DEBUG_MODE set while boot owns → boot keeps the grant until it releases.
- TIMEOUT_CYCLES=16 and HOST_REQ held high → HOST_GNT for 16 cycles, one TIMEOUT_ERR pulse, guard, no regrant while HOST_REQ stays 1. HOST_REQ low then high → granted again after the guard.
- HRESET pulsed for one cycle during a boot grant while FLASH_SS=0 → next cycle FLASH_SS=1, BOOT_GNT=0, OWNER=00. After reset, a pending BOOT_REQ is granted one cycle later.
- No requests for 100 cycles → FLASH_SS=1, FLASH_SCK=SCK_IDLE, FLASH_SDO=0, OWNER=00 throughout, and toggling BOOT_SS/HOST_SS has no effect on the pins.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Two-master arbiter sharing the SPI boot flash between the bootstrap engine and
// the external host, with a chip-select guard gap and a grant-hold watchdog.
module spi_flash_arbiter #(
   parameter int unsigned GUARD_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter logic        SCK_IDLE       = 1'b0
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       DEBUG_MODE,
   input  logic       BOOT_REQ,
   output logic       BOOT_GNT,
   input  logic       BOOT_SCK,
   input  logic       BOOT_SDO,
   input  logic       BOOT_SS,
   output logic       BOOT_SDI,
   input  logic       HOST_REQ,
   output logic       HOST_GNT,
   input  logic       HOST_SCK,
   input  logic       HOST_SDO,
   input  logic       HOST_SS,
   output logic       HOST_SDI,
   output logic       FLASH_SCK,
   output logic       FLASH_SDO,
   output logic       FLASH_SS,
   input  logic       FLASH_SDI,
   output logic [1:0] OWNER,
   output logic       TIMEOUT_ERR
);

   // Encoding doubles as the OWNER code.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      GNT_BOOT = 2'b01,
      GNT_HOST = 2'b10,
      GUARD    = 2'b11
   } state_t;

   localparam logic [7:0]  GUARD_LOAD  = 8'(GUARD_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_VAL = 24'(TIMEOUT_CYCLES);

   state_t      state;
   logic [7:0]  guard_cnt;
   logic [23:0] hold_cnt;
   logic        lock_boot;
   logic        lock_host;

   logic boot_elig, host_elig, granted, owner_req, timeout_hit;

   assign boot_elig   = BOOT_REQ && !DEBUG_MODE && !lock_boot;
   assign host_elig   = HOST_REQ && !lock_host;
   assign granted     = (state == GNT_BOOT) || (state == GNT_HOST);
   assign owner_req   = (state == GNT_BOOT) ? BOOT_REQ : HOST_REQ;
   assign timeout_hit = granted && (TIMEOUT_VAL != 24'd0) && (hold_cnt == TIMEOUT_VAL);

   // NOTE: all state uses non-blocking assignments and the reset branch is
   // sampled on the clock edge, so every register updates from pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= IDLE;
         guard_cnt <= 8'd0;
         hold_cnt  <= 24'd0;
         lock_boot <= 1'b0;
         lock_host <= 1'b0;
      end else begin
         // A watchdog lockout lasts until the master drops its request.
         lock_boot <= BOOT_REQ && (lock_boot || (timeout_hit && state == GNT_BOOT));
         lock_host <= HOST_REQ && (lock_host || (timeout_hit && state == GNT_HOST));

         case (state)
            GNT_BOOT, GNT_HOST: begin
               if (timeout_hit || !owner_req) begin
                  state     <= GUARD;
                  guard_cnt <= GUARD_LOAD;
               end else begin
                  hold_cnt <= hold_cnt + 24'd1;
               end
            end
            default: begin
               if (state == GUARD && guard_cnt != 8'd0) begin
                  guard_cnt <= guard_cnt - 8'd1;
               end else if (boot_elig) begin
                  state    <= GNT_BOOT;
                  hold_cnt <= 24'd1;
               end else if (host_elig) begin
                  state    <= GNT_HOST;
                  hold_cnt <= 24'd1;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign BOOT_GNT    = (state == GNT_BOOT);
   assign HOST_GNT    = (state == GNT_HOST);
   assign OWNER       = state;
   assign TIMEOUT_ERR = timeout_hit;
   assign BOOT_SDI    = FLASH_SDI;
   assign HOST_SDI    = FLASH_SDI;

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      FLASH_SCK = SCK_IDLE;
      FLASH_SDO = 1'b0;
      FLASH_SS  = 1'b1;
      if (state == GNT_BOOT) begin
         FLASH_SCK = BOOT_SCK;
         FLASH_SDO = BOOT_SDO;
         FLASH_SS  = BOOT_SS;
      end else if (state == GNT_HOST) begin
         FLASH_SCK = HOST_SCK;
         FLASH_SDO = HOST_SDO;
         FLASH_SS  = HOST_SS;
      end
   end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a behavioural ownership model.
module tb_spi_flash_arbiter;

   localparam int   GUARD   = 4;
   localparam int   TIMEOUT = 16;
   localparam logic SCK_IDL = 1'b1;

   logic HCLK = 1'b0;
   logic HRESET, DEBUG_MODE;
   logic BOOT_REQ, BOOT_SCK, BOOT_SDO, BOOT_SS;
   logic HOST_REQ, HOST_SCK, HOST_SDO, HOST_SS;
   logic FLASH_SDI;
   logic BOOT_GNT, BOOT_SDI, HOST_GNT, HOST_SDI;
   logic FLASH_SCK, FLASH_SDO, FLASH_SS, TIMEOUT_ERR;
   logic [1:0] OWNER;

   int checks = 0;
   int failures = 0;
   bit rand_pins = 1'b1;

   // Model: who owns the flash (0 none, 1 boot, 2 host, 3 guard), how many
   // guard cycles remain including the current one, how long the grant has lasted.
   int m_owner = 0;
   int m_guard_left = 0;
   int m_held = 0;
   bit m_lock_b = 1'b0;
   bit m_lock_h = 1'b0;

   spi_flash_arbiter #(
      .GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TIMEOUT), .SCK_IDLE(SCK_IDL)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .DEBUG_MODE(DEBUG_MODE),
      .BOOT_REQ(BOOT_REQ), .BOOT_GNT(BOOT_GNT), .BOOT_SCK(BOOT_SCK),
      .BOOT_SDO(BOOT_SDO), .BOOT_SS(BOOT_SS), .BOOT_SDI(BOOT_SDI),
      .HOST_REQ(HOST_REQ), .HOST_GNT(HOST_GNT), .HOST_SCK(HOST_SCK),
      .HOST_SDO(HOST_SDO), .HOST_SS(HOST_SS), .HOST_SDI(HOST_SDI),
      .FLASH_SCK(FLASH_SCK), .FLASH_SDO(FLASH_SDO), .FLASH_SS(FLASH_SS),
      .FLASH_SDI(FLASH_SDI), .OWNER(OWNER), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_grant(input bit eb, input bit eh);
      if (eb) begin
         m_owner = 1; m_held = 1;
      end else if (eh) begin
         m_owner = 2; m_held = 1;
      end else begin
         m_owner = 0;
      end
   endtask

   // Advance the model across one rising edge using the inputs it will sample.
   task automatic model_step();
      bit tnow, eb, eh, own_req;
      int old_owner;
      if (HRESET) begin
         m_owner = 0; m_guard_left = 0; m_held = 0; m_lock_b = 0; m_lock_h = 0;
         return;
      end
      old_owner = m_owner;
      tnow = (m_owner == 1 || m_owner == 2) && m_held == TIMEOUT;
      eb = BOOT_REQ && !DEBUG_MODE && !m_lock_b;
      eh = HOST_REQ && !m_lock_h;
      own_req = (m_owner == 1) ? BOOT_REQ : HOST_REQ;
      case (m_owner)
         0: model_grant(eb, eh);
         1, 2: begin
            if (tnow || !own_req) begin
               m_owner = 3; m_guard_left = GUARD;
            end else begin
               m_held++;
            end
         end
         default: begin
            if (m_guard_left == 1) model_grant(eb, eh);
            else m_guard_left--;
         end
      endcase
      m_lock_b = BOOT_REQ && (m_lock_b || (tnow && old_owner == 1));
      m_lock_h = HOST_REQ && (m_lock_h || (tnow && old_owner == 2));
   endtask

   task automatic compare_all();
      logic e_ss, e_sck, e_sdo;
      e_ss = 1'b1; e_sck = SCK_IDL; e_sdo = 1'b0;
      if (m_owner == 1) begin
         e_ss = BOOT_SS; e_sck = BOOT_SCK; e_sdo = BOOT_SDO;
      end else if (m_owner == 2) begin
         e_ss = HOST_SS; e_sck = HOST_SCK; e_sdo = HOST_SDO;
      end
      check("boot_gnt", 32'(BOOT_GNT), 32'(m_owner == 1));
      check("host_gnt", 32'(HOST_GNT), 32'(m_owner == 2));
      check("owner", 32'(OWNER), 32'(m_owner));
      check("timeout_err", 32'(TIMEOUT_ERR),
            32'((m_owner == 1 || m_owner == 2) && m_held == TIMEOUT));
      check("flash_ss", 32'(FLASH_SS), 32'(e_ss));
      check("flash_sck", 32'(FLASH_SCK), 32'(e_sck));
      check("flash_sdo", 32'(FLASH_SDO), 32'(e_sdo));
      check("boot_sdi", 32'(BOOT_SDI), 32'(FLASH_SDI));
      check("host_sdi", 32'(HOST_SDI), 32'(FLASH_SDI));
   endtask

   // Called right after a falling edge; returns at the next falling edge.
   task automatic tick();
      if (rand_pins) begin
         BOOT_SCK = 1'($urandom); BOOT_SDO = 1'($urandom); BOOT_SS = 1'($urandom);
         HOST_SCK = 1'($urandom); HOST_SDO = 1'($urandom); HOST_SS = 1'($urandom);
         FLASH_SDI = 1'($urandom);
      end
      model_step();
      @(negedge HCLK);
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n, pulses, gnts;
      HRESET = 1'b1; DEBUG_MODE = 1'b0; BOOT_REQ = 1'b0; HOST_REQ = 1'b0;
      BOOT_SCK = 1'b0; BOOT_SDO = 1'b0; BOOT_SS = 1'b1;
      HOST_SCK = 1'b0; HOST_SDO = 1'b0; HOST_SS = 1'b1; FLASH_SDI = 1'b0;
      ticks(2);
      HRESET = 1'b0;
      ticks(2);

      // Host alone: one-cycle grant latency, pins follow host.
      HOST_REQ = 1'b1;
      tick();
      check("host_first_gnt", 32'(HOST_GNT), 32'd1);
      ticks(6);
      HOST_REQ = 1'b0;
      ticks(GUARD + 2);

      // Simultaneous requests: boot first, then exactly GUARD guard cycles.
      BOOT_REQ = 1'b1; HOST_REQ = 1'b1;
      tick();
      check("simul_boot_first", 32'(BOOT_GNT), 32'd1);
      ticks(5);
      BOOT_REQ = 1'b0;
      tick();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (HOST_GNT) break;
         if (OWNER == 2'b11 && FLASH_SS) n++;
         tick();
      end
      check("guard_len", 32'(n), 32'(GUARD));
      check("host_after_guard", 32'(HOST_GNT), 32'd1);
      HOST_REQ = 1'b0;
      ticks(GUARD + 2);

      // Debug mode: boot ignored; setting it mid-boot-grant does not preempt.
      DEBUG_MODE = 1'b1; BOOT_REQ = 1'b1; HOST_REQ = 1'b1;
      ticks(8);
      HOST_REQ = 1'b0;
      ticks(GUARD + 3);
      check("debug_no_boot", 32'(BOOT_GNT), 32'd0);
      BOOT_REQ = 1'b0; DEBUG_MODE = 1'b0;
      tick();
      BOOT_REQ = 1'b1;
      ticks(3);
      DEBUG_MODE = 1'b1;
      ticks(5);
      check("debug_no_preempt", 32'(BOOT_GNT), 32'd1);
      BOOT_REQ = 1'b0;
      ticks(GUARD + 2);
      DEBUG_MODE = 1'b0;

      // Watchdog: host held high -> TIMEOUT grant cycles, one pulse, lockout.
      HOST_REQ = 1'b1;
      pulses = 0; gnts = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (HOST_GNT) gnts++;
         if (TIMEOUT_ERR) pulses++;
      end
      check("wd_grant_cycles", 32'(gnts), 32'(TIMEOUT));
      check("wd_pulses", 32'(pulses), 32'd1);
      check("wd_lockout", 32'(HOST_GNT), 32'd0);
      HOST_REQ = 1'b0;
      tick();
      HOST_REQ = 1'b1;
      tick();
      check("wd_regrant", 32'(HOST_GNT), 32'd1);
      HOST_REQ = 1'b0;
      ticks(GUARD + 2);

      // Reset mid boot transfer with SS low.
      rand_pins = 1'b0;
      BOOT_SS = 1'b0; BOOT_REQ = 1'b1;
      ticks(3);
      check("pre_reset_ss_low", 32'(FLASH_SS), 32'd0);
      HRESET = 1'b1;
      tick();
      check("reset_ss_high", 32'(FLASH_SS), 32'd1);
      HRESET = 1'b0;
      tick();
      check("post_reset_boot", 32'(BOOT_GNT), 32'd1);
      BOOT_REQ = 1'b0;
      rand_pins = 1'b1;
      ticks(GUARD + 2);

      // Idle with toggling select lines.
      ticks(100);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(11) == 0) BOOT_REQ = ~BOOT_REQ;
         if ($urandom_range(11) == 0) HOST_REQ = ~HOST_REQ;
         if ($urandom_range(39) == 0) DEBUG_MODE = ~DEBUG_MODE;
         HRESET = ($urandom_range(299) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
